// File: rtl/instruction_fetch_memory_if.sv
// instruction_fetch_memory_if: fetch request/response and load port bundle
interface instruction_fetch_memory_if #(parameter int ADDR_WIDTH = 64);
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic [ADDR_WIDTH-1:0] Inst_Address;
  logic                  Resp_Valid;
  logic                  Resp_Ready;
  logic [31:0]           Instruction;
  logic [1:0]            Fault;
  logic                  Load_En;
  logic [ADDR_WIDTH-1:0] Load_Addr;
  logic [31:0]           Load_Data;
  logic [3:0]            Load_Mask;
  logic                  Load_Err;
  logic [31:0]           Fetch_Count;
  modport master (
    output Req_Valid, Inst_Address, Resp_Ready, Load_En, Load_Addr, Load_Data, Load_Mask,
    input  Req_Ready, Resp_Valid, Instruction, Fault, Load_Err, Fetch_Count
  );
  modport slave (
    input  Req_Valid, Inst_Address, Resp_Ready, Load_En, Load_Addr, Load_Data, Load_Mask,
    output Req_Ready, Resp_Valid, Instruction, Fault, Load_Err, Fetch_Count
  );
endinterface

// File: rtl/instruction_fetch_memory.sv
// instruction_fetch_memory: loadable little-endian instruction store with registered, handshaked fetch
module instruction_fetch_memory #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input logic clk,
  input logic reset,
  instruction_fetch_memory_if.slave bus
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH_BYTES - 4);
  logic [31:0] mem [WORDS];
  logic        accept;
  logic [1:0]  req_fault, load_fault;
  // range test compares against the last legal word address so a near-max address cannot wrap
  function automatic logic [1:0] fault_of(input logic [ADDR_WIDTH-1:0] a);
    return a > LAST ? 2'b10 : (a[1:0] != 2'b00 ? 2'b01 : 2'b00);
  endfunction
  assign req_fault     = fault_of(bus.Inst_Address);
  assign load_fault    = fault_of(bus.Load_Addr);
  assign bus.Req_Ready = !bus.Load_En && (!bus.Resp_Valid || bus.Resp_Ready);
  assign accept        = bus.Req_Valid && bus.Req_Ready;
  // byte-masked load; deliberately outside reset so a load in the reset cycle still lands
  always_ff @(posedge clk)
    if (bus.Load_En && load_fault == 2'b00)
      for (int i = 0; i < 4; i++)
        if (bus.Load_Mask[i]) mem[bus.Load_Addr[IW+1:2]][8*i +: 8] <= bus.Load_Data[8*i +: 8];
  // response register, load error pulse and saturating fetch counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.Resp_Valid  <= 1'b0;
      bus.Instruction <= '0;
      bus.Fault       <= '0;
      bus.Load_Err    <= 1'b0;
      bus.Fetch_Count <= '0;
    end else begin
      bus.Load_Err <= bus.Load_En && load_fault != 2'b00;
      if (accept) begin
        bus.Resp_Valid  <= 1'b1;
        bus.Fault       <= req_fault;
        bus.Instruction <= req_fault != 2'b00 ? NOP_WORD : mem[bus.Inst_Address[IW+1:2]];
        bus.Fetch_Count <= &bus.Fetch_Count ? bus.Fetch_Count : bus.Fetch_Count + 32'd1;
      end else if (bus.Resp_Ready) begin
        bus.Resp_Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_memory.sv
// tb_instruction_fetch_memory: directed plan plus randomized traffic against a byte-level reference model
module tb_instruction_fetch_memory;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0;
  logic reset = 0;
  int n_total = 0;
  int n_pass = 0;
  logic [7:0]  m_mem [DEPTH];
  logic        m_rv = 0;
  logic [31:0] m_inst = 0;
  logic [1:0]  m_fault = 0;
  logic        m_lerr = 0;
  logic [31:0] m_cnt = 0;
  instruction_fetch_memory_if #(.ADDR_WIDTH(64)) bus ();
  instruction_fetch_memory #(.ADDR_WIDTH(64), .DEPTH_BYTES(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [1:0] m_fault_of(input logic [63:0] a);
    if (a > 64'(DEPTH - 4)) return 2'b10;
    if (a % 4 != 0) return 2'b01;
    return 2'b00;
  endfunction
  task automatic step(input logic rn, input logic rv, input logic [63:0] a, input logic rr,
                      input logic le = 0, input logic [63:0] la = 0, input logic [31:0] ld = 0,
                      input logic [3:0] lm = 0);
    logic rdy;
    logic [1:0] f;
    @(negedge clk);
    check("resp_valid", bus.Resp_Valid, m_rv);
    if (m_rv) begin
      check("instruction", bus.Instruction, m_inst);
      check("fault", bus.Fault, m_fault);
    end
    check("load_err", bus.Load_Err, m_lerr);
    check("fetch_count", bus.Fetch_Count, m_cnt);
    reset = rn;
    bus.Req_Valid = rv;
    bus.Inst_Address = a;
    bus.Resp_Ready = rr;
    bus.Load_En = le;
    bus.Load_Addr = la;
    bus.Load_Data = ld;
    bus.Load_Mask = lm;
    #1;
    rdy = !le && (!m_rv || rr);
    check("req_ready", bus.Req_Ready, rdy);
    @(posedge clk);
    if (le && m_fault_of(la) == 2'b00)
      for (int i = 0; i < 4; i++)
        if (lm[i]) m_mem[int'(la) + i] = ld[8*i +: 8];
    if (!rn) begin
      m_rv = 0; m_inst = 0; m_fault = 0; m_lerr = 0; m_cnt = 0;
    end else begin
      m_lerr = le && m_fault_of(la) != 2'b00;
      if (rv && rdy) begin
        f = m_fault_of(a);
        m_rv = 1;
        m_fault = f;
        m_inst = f != 0 ? NOP : {m_mem[int'(a)+3], m_mem[int'(a)+2], m_mem[int'(a)+1], m_mem[int'(a)]};
        if (m_cnt != 32'hFFFFFFFF) m_cnt++;
      end else if (rr) m_rv = 0;
    end
  endtask
  function automatic logic [63:0] pick();
    int r = $urandom_range(0, 19);
    if (r == 0) return {$urandom, $urandom};
    if (r == 1) return 64'($urandom_range(DEPTH - 8, DEPTH + 8));
    return 64'($urandom_range(0, DEPTH / 4 - 1)) * 4 + 64'(r == 2 ? $urandom_range(1, 3) : 0);
  endfunction
  initial begin
    bus.Req_Valid = 0; bus.Inst_Address = 0; bus.Resp_Ready = 1;
    bus.Load_En = 0; bus.Load_Addr = 0; bus.Load_Data = 0; bus.Load_Mask = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 1, 1, 0, 32'h00000513, 4'hF);
    step(1, 0, 0, 1, 1, 4, 32'h01400593, 4'hF);
    step(1, 1, 0, 1);
    #2 check("plan_inst0", bus.Instruction, 32'h00000513);
    step(1, 1, 4, 1);
    #2 check("plan_inst4", bus.Instruction, 32'h01400593);
    check("plan_count2", bus.Fetch_Count, 32'd2);
    step(1, 1, 2, 1);
    #2 check("plan_misaligned", {bus.Fault, bus.Instruction}, {2'b01, NOP});
    step(1, 1, DEPTH - 2, 1);
    #2 check("plan_oor_edge", {bus.Fault, bus.Instruction}, {2'b10, NOP});
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    #2 check("plan_oor_wrap", {bus.Fault, bus.Instruction}, {2'b10, NOP});
    step(1, 1, 4, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4, 0);
      #2 check("plan_hold_inst", bus.Instruction, 32'h01400593);
      check("plan_hold_count", bus.Fetch_Count, 32'd6);
    end
    step(1, 1, 4, 1);
    step(1, 0, 0, 1, 1, 0, 32'hAABBCCDD, 4'b0010);
    step(1, 1, 0, 1);
    #2 check("plan_mask", bus.Instruction, 32'h0000CC13);
    step(1, 0, 0, 1, 1, 6, 32'hDEADBEEF, 4'hF);
    #2 check("plan_load_err", bus.Load_Err, 1'b1);
    step(1, 1, 4, 1);
    #2 check("plan_load_err_clear", bus.Load_Err, 1'b0);
    check("plan_mem_unchanged", bus.Instruction, 32'h01400593);
    step(1, 1, 0, 1, 1, 0, 32'h12345678, 4'hF);
    step(1, 1, 0, 1);
    #2 check("plan_load_then_fetch", bus.Instruction, 32'h12345678);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    #2 check("plan_rst_valid", bus.Resp_Valid, 1'b0);
    check("plan_rst_count", bus.Fetch_Count, 32'd0);
    check("plan_rst_inst_fault", {bus.Fault, bus.Instruction}, 34'd0);
    step(1, 1, 0, 1);
    #2 check("plan_mem_survives_reset", bus.Instruction, 32'h12345678);
    for (int w = 0; w < DEPTH / 4; w++) step(1, 0, 0, 1, 1, 64'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, pick(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 2, pick(), $urandom, 4'($urandom));
    step(1, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
